// File: rtl/pulpemu_rst_seq.sv
// Reset sequencer for the PULP FPGA emulator.
// Drives the chip's active-low pad reset. It waits for a stable clock-manager
// lock, holds the chip in reset for a fixed time and then releases it.
// It re-enters reset when lock is lost or when the debounced user button is pressed.
module pulpemu_rst_seq #(
   parameter int unsigned SYNC_STAGES        = 2,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned HOLD_CYCLES        = 256,
   parameter int unsigned DEBOUNCE_CYCLES    = 8192,
   parameter int unsigned CNT_W              = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             mmcm_locked_i,
   input  logic             btn_rst_i,
   input  logic             clr_lost_i,
   output logic             pulp_rst_no,
   output logic             rst_done_o,
   output logic             lock_lost_o,
   output logic [CNT_W-1:0] rst_count_o,
   output logic [1:0]       state_o
);

   localparam int unsigned LOCK_W = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

   // Terminal values of the counters, sized to the counter that uses them
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_STABLE_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_HOLD      = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   state_t                  state_r;
   logic [SYNC_STAGES-1:0]  lock_sync_r;
   logic [SYNC_STAGES-1:0]  btn_sync_r;
   logic                    locked_s;
   logic                    btn_s;
   logic                    btn_db_r;
   logic [DB_W-1:0]         db_cnt_r;
   logic                    press_r;
   logic [LOCK_W-1:0]       stable_cnt_r;
   logic [HOLD_W-1:0]       hold_cnt_r;
   logic                    lost_evt_s;
   logic                    hold_entry_s;

   assign locked_s = lock_sync_r[SYNC_STAGES-1];
   assign btn_s    = btn_sync_r[SYNC_STAGES-1];
   assign state_o  = state_r;

   // Bring the asynchronous lock and button inputs into the clk_i domain
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lock_sync_r <= {SYNC_STAGES{1'b0}};
         btn_sync_r  <= {SYNC_STAGES{1'b0}};
      end else begin
         lock_sync_r <= {lock_sync_r[SYNC_STAGES-2:0], mmcm_locked_i};
         btn_sync_r  <= {btn_sync_r[SYNC_STAGES-2:0], btn_rst_i};
      end
   end

   // Debounce the button. The filtered value follows only after a long enough
   // stable run. A rising edge of the filtered value raises press_r for one cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         btn_db_r <= 1'b0;
         db_cnt_r <= {DB_W{1'b0}};
         press_r  <= 1'b0;
      end else begin
         press_r <= 1'b0;
         if (btn_s == btn_db_r) begin
            db_cnt_r <= {DB_W{1'b0}};
         end else if (db_cnt_r == DB_LAST) begin
            btn_db_r <= btn_s;
            db_cnt_r <= {DB_W{1'b0}};
            press_r  <= btn_s;
         end else begin
            db_cnt_r <= db_cnt_r + DB_W'(1);
         end
      end
   end

   // Decode the lock-loss and HOLD-entry events for the current cycle.
   // Lock loss outranks a button press.
   always_comb begin
      lost_evt_s   = 1'b0;
      hold_entry_s = 1'b0;
      case (state_r)
         ST_WAIT_LOCK: begin
            hold_entry_s = (stable_cnt_r == LOCK_LAST);
         end
         ST_HOLD: begin
            lost_evt_s = ~locked_s;
         end
         ST_RUN: begin
            lost_evt_s   = ~locked_s;
            hold_entry_s = locked_s & press_r;
         end
         default: begin
            lost_evt_s   = 1'b0;
            hold_entry_s = 1'b0;
         end
      endcase
   end

   // Sequencer FSM. The chip reset and done flag are registered together
   // with the state, so both are high exactly when the new state is RUN.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r      <= ST_IDLE;
         stable_cnt_r <= {LOCK_W{1'b0}};
         hold_cnt_r   <= {HOLD_W{1'b0}};
         pulp_rst_no  <= 1'b0;
         rst_done_o   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_r      <= ST_WAIT_LOCK;
               stable_cnt_r <= {LOCK_W{1'b0}};
               pulp_rst_no  <= 1'b0;
               rst_done_o   <= 1'b0;
            end
            ST_WAIT_LOCK: begin
               pulp_rst_no <= 1'b0;
               rst_done_o  <= 1'b0;
               if (hold_entry_s) begin
                  state_r      <= ST_HOLD;
                  stable_cnt_r <= {LOCK_W{1'b0}};
                  hold_cnt_r   <= {HOLD_W{1'b0}};
               end else if (locked_s) begin
                  stable_cnt_r <= stable_cnt_r + LOCK_W'(1);
               end else begin
                  stable_cnt_r <= {LOCK_W{1'b0}};
               end
            end
            ST_HOLD: begin
               if (lost_evt_s) begin
                  state_r      <= ST_WAIT_LOCK;
                  stable_cnt_r <= {LOCK_W{1'b0}};
                  pulp_rst_no  <= 1'b0;
                  rst_done_o   <= 1'b0;
               end else if (hold_cnt_r == HOLD_LAST) begin
                  state_r     <= ST_RUN;
                  pulp_rst_no <= 1'b1;
                  rst_done_o  <= 1'b1;
               end else begin
                  hold_cnt_r  <= hold_cnt_r + HOLD_W'(1);
                  pulp_rst_no <= 1'b0;
                  rst_done_o  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (lost_evt_s) begin
                  state_r      <= ST_WAIT_LOCK;
                  stable_cnt_r <= {LOCK_W{1'b0}};
                  pulp_rst_no  <= 1'b0;
                  rst_done_o   <= 1'b0;
               end else if (hold_entry_s) begin
                  state_r     <= ST_HOLD;
                  hold_cnt_r  <= {HOLD_W{1'b0}};
                  pulp_rst_no <= 1'b0;
                  rst_done_o  <= 1'b0;
               end else begin
                  pulp_rst_no <= 1'b1;
                  rst_done_o  <= 1'b1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               pulp_rst_no <= 1'b0;
               rst_done_o  <= 1'b0;
            end
         endcase
      end
   end

   // Status flags: a sticky lock-lost flag (a set beats a clear) and a saturating count of HOLD entries
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lock_lost_o <= 1'b0;
         rst_count_o <= {CNT_W{1'b0}};
      end else begin
         if (lost_evt_s) begin
            lock_lost_o <= 1'b1;
         end else if (clr_lost_i) begin
            lock_lost_o <= 1'b0;
         end else begin
            lock_lost_o <= lock_lost_o;
         end
         if (hold_entry_s && (rst_count_o != CNT_MAX)) begin
            rst_count_o <= rst_count_o + CNT_W'(1);
         end else begin
            rst_count_o <= rst_count_o;
         end
      end
   end

endmodule

// File: doc/pulpemu_rst_seq.md
Name: pulpemu_rst_seq

Overview:
Reset sequencer that sits directly upstream of the PULP chip's pad_reset_n input on the FPGA emulator.
- Waits for the clock manager's locked output to be stable, then holds the chip in reset for a fixed time, then releases it.
- Re-enters reset on clock-lock loss or on a debounced user reset button.
- Runs on the emulator's reference clock domain and exports status for LEDs and debug.

Parameters:
SYNC_STAGES, 2, flops in each async-input synchronizer (min 2)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized locked=1 samples needed before leaving WAIT_LOCK (min 1)
HOLD_CYCLES, 256, cycles pulp_rst_no stays low in HOLD (min 1)
DEBOUNCE_CYCLES, 8192, cycles the synchronized button must be stable before its debounced value changes (min 1)
CNT_W, 8, width of reset-event counter

Ports:
clk_i  input  1  sequencer clock (pulp_ref_clk domain)
rst_i  input  1  reset: synchronous, active-high
mmcm_locked_i  input  1  clock-manager lock, async, synchronized internally
btn_rst_i  input  1  user reset button, async, active-high, bouncy
clr_lost_i  input  1  single-cycle pulse, clears lock_lost_o
pulp_rst_no  output  1  active-low chip reset, to pad_reset_n
rst_done_o  output  1  high while state==RUN
lock_lost_o  output  1  sticky: lock was lost while in HOLD or RUN
rst_count_o  output  CNT_W  number of HOLD entries, saturating
state_o  output  2  encoding IDLE=0, WAIT_LOCK=1, HOLD=2, RUN=3

Behaviour:
- All outputs are registered. While rst_i=1 at a clock edge:
  - state=IDLE, pulp_rst_no=0, rst_done_o=0, lock_lost_o=0, rst_count_o=0.
  - All synchronizer, debounce and hold counters clear; the debounced button value = 0.
- rst_i asserted mid-operation aborts any state on the next edge, with identical values.
- Synchronizers: locked_s = mmcm_locked_i delayed by SYNC_STAGES flops; btn_s likewise from btn_rst_i.
- Debounce:
  - The counter increments while btn_s != btn_db and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with btn_s still != btn_db, btn_db <= btn_s and the counter clears.
  - press = btn_db 0->1 transition, a one-cycle pulse.
- FSM:
  - IDLE -> WAIT_LOCK unconditionally on the first edge after rst_i=0.
  - WAIT_LOCK:
    - The stable counter increments while locked_s=1 and clears when locked_s=0.
    - After LOCK_STABLE_CYCLES consecutive locked_s=1 cycles -> HOLD.
    - Button presses are ignored.
  - HOLD:
    - pulp_rst_no=0 for exactly HOLD_CYCLES cycles, then -> RUN.
    - locked_s=0 -> WAIT_LOCK and set lock_lost_o.
    - press is ignored (the hold is not restarted).
  - RUN:
    - pulp_rst_no=1, rst_done_o=1.
    - locked_s=0 -> WAIT_LOCK and set lock_lost_o.
    - Otherwise press -> HOLD.
    - Lock loss has priority over press in the same cycle.
- pulp_rst_no and rst_done_o update on the same edge as the state register; both are 1 iff the new state is RUN.
- rst_count_o increments by 1 on every entry into HOLD and saturates at 2^CNT_W-1 (no wrap).
- lock_lost_o:
  - clr_lost_i clears it.
  - A simultaneous set and clear leaves it at 1.
  - Lock loss in WAIT_LOCK or IDLE does not set it.
- Latency: with mmcm_locked_i steady high from edge 0, pulp_rst_no rises SYNC_STAGES+LOCK_STABLE_CYCLES+HOLD_CYCLES+1 edges after rst_i deasserts (the +1 is the IDLE cycle).
- No combinational path from any input to any output.

Test Plan:
Bench parameters: SYNC_STAGES=2, LOCK_STABLE_CYCLES=4, HOLD_CYCLES=3, DEBOUNCE_CYCLES=5, CNT_W=2.
1. Power-up: locked=1 throughout, release rst_i at edge 0 -> pulp_rst_no rises at edge 10; state_o sequence 0,1x6,2x3,3; rst_count_o=1; lock_lost_o=0.
2. Lock glitch in WAIT_LOCK: locked_s drops for 1 cycle after 3 high samples -> counter restarts; HOLD entered only after 4 further consecutive highs; lock_lost_o stays 0.
3. Lock loss in RUN: mmcm_locked_i falls -> 2 edges later state_o=1, pulp_rst_no=0, lock_lost_o=1. Assert clr_lost_i alone -> lock_lost_o=0 next edge. Assert clr_lost_i in the same cycle as a new loss -> lock_lost_o stays 1.
4. Button bounce: toggle btn_rst_i every 2 cycles for 20 cycles, then hold 1 -> exactly one press; state goes RUN->HOLD 3 cycles->RUN; rst_count_o increments once. A 4-cycle pulse produces no press.
5. Saturation and priority: 4 presses -> rst_count_o=3 (saturated). Press and lock loss in the same cycle -> WAIT_LOCK, and rst_count_o unchanged.
6. rst_i asserted during HOLD -> next edge all outputs at reset values; after release the full sequence of scenario 1 repeats.
